// File: rtl/noc_node_receiver_if.sv
// Handshake bundle between the router local output, the ejection endpoint and the host.
// The slave modport is the receiver's view; master is the environment driving flits and draining words.
interface noc_node_receiver_if #(
   parameter int DATA_W = 32
);
   logic              from_valid;
   logic              from_head;
   logic              from_tail;
   logic [DATA_W-1:0] from_data;
   logic              from_ready;
   logic              pkt_valid;
   logic              pkt_ready;
   logic [DATA_W-1:0] pkt_data;
   logic [1:0]        pkt_src_x;
   logic [1:0]        pkt_src_y;
   logic              pkt_last;

   modport master (
      output from_valid, from_head, from_tail, from_data, pkt_ready,
      input  from_ready, pkt_valid, pkt_data, pkt_src_x, pkt_src_y, pkt_last
   );

   modport slave (
      input  from_valid, from_head, from_tail, from_data, pkt_ready,
      output from_ready, pkt_valid, pkt_data, pkt_src_x, pkt_src_y, pkt_last
   );
endinterface

// File: rtl/noc_node_receiver.sv
// Mesh node ejection endpoint: dest/len checks, store-and-forward FIFO, optional NOC_RX_STATS_EN counters.
// pkt_valid rises 1 cycle after the tail is accepted; from_ready drops when speculative occupancy hits FIFO_DEPTH.
module noc_node_receiver #(
   parameter int DATA_W     = 32,
   parameter int X_ADDR     = 0,
   parameter int Y_ADDR     = 0,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   noc_node_receiver_if.slave   io,
   output logic                 err_misroute,
   output logic                 err_len,
   output logic                 err_proto,
   output logic [15:0]          pkt_count,
   output logic [15:0]          drop_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
   localparam logic [1:0]    MY_X    = 2'(X_ADDR);
   localparam logic [1:0]    MY_Y    = 2'(Y_ADDR);

   typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

   state_t          state, state_n;
   logic [3:0]      cnt, cnt_n;
   logic [1:0]      src_x, src_y, src_x_n, src_y_n;
   logic [PW-1:0]   wr_ptr, cm_ptr, rd_ptr, occ;
   logic            wr_en, commit, abort;
   logic            mis_n, len_n, proto_n;

   logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
   logic              mem_last [FIFO_DEPTH];
   logic [3:0]        mem_src  [FIFO_DEPTH];

   logic [1:0] hdr_dst_x, hdr_dst_y, hdr_src_x, hdr_src_y;
   logic [3:0] hdr_len;
   logic       space;

   assign hdr_dst_x = io.from_data[31:30];
   assign hdr_dst_y = io.from_data[29:28];
   assign hdr_src_x = io.from_data[27:26];
   assign hdr_src_y = io.from_data[25:24];
   assign hdr_len   = io.from_data[23:20];
   assign occ       = wr_ptr - rd_ptr;
   assign space     = occ < DEPTH_P;

   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      src_x_n       = src_x;
      src_y_n       = src_y;
      wr_en         = 1'b0;
      commit        = 1'b0;
      abort         = 1'b0;
      mis_n         = 1'b0;
      len_n         = 1'b0;
      proto_n       = 1'b0;
      io.from_ready = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               io.from_ready = 1'b1;
               if (io.from_valid) begin
                  if (!io.from_head || io.from_tail) begin
                     proto_n = 1'b1;
                  end else if (hdr_len == 4'd0) begin
                     len_n = 1'b1;
                  end else if (int'(hdr_len) > FIFO_DEPTH) begin
                     len_n   = 1'b1;
                     cnt_n   = hdr_len;
                     state_n = DROP;
                  end else if (hdr_dst_x != MY_X || hdr_dst_y != MY_Y) begin
                     mis_n   = 1'b1;
                     cnt_n   = hdr_len;
                     state_n = DROP;
                  end else begin
                     src_x_n = hdr_src_x;
                     src_y_n = hdr_src_y;
                     cnt_n   = hdr_len;
                     state_n = PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               // A header mid-packet is left on the bus and replayed from IDLE.
               if (io.from_valid && io.from_head) begin
                  abort   = 1'b1;
                  proto_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  io.from_ready = space;
                  if (io.from_valid && space) begin
                     if (io.from_tail != (cnt == 4'd1)) begin
                        abort   = 1'b1;
                        proto_n = 1'b1;
                        state_n = IDLE;
                     end else begin
                        wr_en = 1'b1;
                        cnt_n = cnt - 4'd1;
                        if (cnt == 4'd1) begin
                           commit  = 1'b1;
                           state_n = IDLE;
                        end
                     end
                  end
               end
            end
            DROP: begin
               if (io.from_valid && io.from_head) begin
                  proto_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  io.from_ready = 1'b1;
                  if (io.from_valid) begin
                     cnt_n = cnt - 4'd1;
                     if (cnt <= 4'd1) state_n = IDLE;
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         src_x        <= 2'd0;
         src_y        <= 2'd0;
         wr_ptr       <= '0;
         cm_ptr       <= '0;
         rd_ptr       <= '0;
         err_misroute <= 1'b0;
         err_len      <= 1'b0;
         err_proto    <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         src_x        <= src_x_n;
         src_y        <= src_y_n;
         err_misroute <= mis_n;
         err_len      <= len_n;
         err_proto    <= proto_n;
         if (abort)      wr_ptr <= cm_ptr;
         else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (commit)     cm_ptr <= wr_ptr + 1'b1;
         if (io.pkt_valid && io.pkt_ready) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_data[wr_ptr[AW-1:0]] <= io.from_data;
         mem_last[wr_ptr[AW-1:0]] <= (cnt == 4'd1);
         mem_src[wr_ptr[AW-1:0]]  <= {src_x, src_y};
      end
   end

   // Outputs are gated so the unreset storage never leaks X to the host.
   assign io.pkt_valid = (rd_ptr != cm_ptr);
   assign io.pkt_data  = io.pkt_valid ? mem_data[rd_ptr[AW-1:0]] : '0;
   assign io.pkt_last  = io.pkt_valid ? mem_last[rd_ptr[AW-1:0]] : 1'b0;
   assign io.pkt_src_x = io.pkt_valid ? mem_src[rd_ptr[AW-1:0]][3:2] : 2'd0;
   assign io.pkt_src_y = io.pkt_valid ? mem_src[rd_ptr[AW-1:0]][1:0] : 2'd0;

`ifdef NOC_RX_STATS_EN
   logic [15:0] pkt_cnt_q, drop_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt_q  <= 16'd0;
         drop_cnt_q <= 16'd0;
      end else begin
         if (commit && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
         if ((mis_n || len_n || abort) && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign pkt_count  = pkt_cnt_q;
   assign drop_count = drop_cnt_q;
`else
   assign pkt_count  = 16'd0;
   assign drop_count = 16'd0;
`endif
endmodule

// File: tb/tb_noc_node_receiver.sv
// Directed bench for noc_node_receiver at node (1,2) with an 8-entry FIFO.
module tb_noc_node_receiver;
`ifdef NOC_RX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic        last;
      logic [1:0]  sx;
      logic [1:0]  sy;
      logic [31:0] d;
   } word_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        err_misroute, err_len, err_proto;
   logic [15:0] pkt_count, drop_count;

   int n_cmp = 0;
   int n_fail = 0;
   int n_mis = 0;
   int n_len = 0;
   int n_proto = 0;
   int stalls = 0;
   int s0;
   word_t rxq[$];
   word_t expq[$];

   noc_node_receiver_if #(.DATA_W(32)) bus ();

   noc_node_receiver #(.DATA_W(32), .X_ADDR(1), .Y_ADDR(2), .FIFO_DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .io           (bus),
      .err_misroute (err_misroute),
      .err_len      (err_len),
      .err_proto    (err_proto),
      .pkt_count    (pkt_count),
      .drop_count   (drop_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (err_misroute) n_mis++;
      if (err_len) n_len++;
      if (err_proto) n_proto++;
      if (bus.pkt_valid && bus.pkt_ready)
         rxq.push_back('{bus.pkt_last, bus.pkt_src_x, bus.pkt_src_y, bus.pkt_data});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected run to end");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic h, input logic t, input logic [31:0] d);
      logic ok;
      int waits;
      ok = 1'b0;
      waits = 0;
      bus.from_valid = 1'b1;
      bus.from_head  = h;
      bus.from_tail  = t;
      bus.from_data  = d;
      while (!ok && waits < 64) begin
         @(negedge clk);
         ok = bus.from_ready;
         @(posedge clk);
         #1;
         if (!ok) begin
            waits++;
            stalls++;
         end
      end
      bus.from_valid = 1'b0;
      bus.from_head  = 1'b0;
      bus.from_tail  = 1'b0;
      chk("send_accept", {63'd0, ok}, 64'd1);
   endtask

   task automatic expect_word(input logic [31:0] d, input logic last);
      expq.push_back('{last, 2'd3, 2'd0, d});
   endtask

   task automatic check_words(input string tag);
      int n;
      chk({tag, "_count"}, rxq.size(), expq.size());
      n = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
      for (int i = 0; i < n; i++)
         chk({tag, "_word"}, {27'd0, rxq[i]}, {27'd0, expq[i]});
      rxq.delete();
      expq.delete();
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.from_valid = 1'b0;
      bus.from_head  = 1'b0;
      bus.from_tail  = 1'b0;
      bus.from_data  = 32'd0;
      bus.pkt_ready  = 1'b1;

      // reset state
      idle_cycles(2);
      @(negedge clk);
      chk("rst_from_ready", bus.from_ready, 0);
      chk("rst_pkt_valid", bus.pkt_valid, 0);
      chk("rst_pkt_data", bus.pkt_data, 0);
      chk("rst_errs", {err_misroute, err_len, err_proto}, 0);
      chk("rst_pkt_count", pkt_count, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_from_ready", bus.from_ready, 1);
      @(posedge clk);
      #1;

      // good packet, src (3,0)
      send(1, 0, 32'h6C30_0000);
      send(0, 0, 32'hA);
      send(0, 0, 32'hB);
      chk("t1_valid_before_tail", bus.pkt_valid, 0);
      send(0, 1, 32'hC);
      chk("t1_valid_after_tail", bus.pkt_valid, 1);
      chk("t1_first_data", bus.pkt_data, 32'hA);
      expect_word(32'hA, 0);
      expect_word(32'hB, 0);
      expect_word(32'hC, 1);
      idle_cycles(5);
      check_words("t1");
      chk("t1_drained", bus.pkt_valid, 0);
      chk("t1_pkt_count", pkt_count, STATS ? 16'd1 : 16'd0);

      // misrouted packet
      s0 = stalls;
      send(1, 0, 32'hAC30_0000);
      send(0, 0, 32'h1);
      send(0, 0, 32'h2);
      send(0, 1, 32'h3);
      idle_cycles(3);
      chk("t2_misroute", n_mis, 1);
      chk("t2_no_stall", stalls - s0, 0);
      chk("t2_proto", n_proto, 0);
      check_words("t2");
      chk("t2_drop_count", drop_count, STATS ? 16'd1 : 16'd0);

      // backpressure: host stalled, second packet fills FIFO
      bus.pkt_ready = 1'b0;
      send(1, 0, 32'h6C50_0000);
      for (int i = 1; i <= 5; i++) begin
         send(0, i == 5, 32'h30 + i);
         expect_word(32'h30 + i, i == 5);
      end
      idle_cycles(1);
      chk("t3_first_committed", bus.pkt_valid, 1);
      send(1, 0, 32'h6C50_0000);
      send(0, 0, 32'h41);
      send(0, 0, 32'h42);
      send(0, 0, 32'h43);
      bus.from_valid = 1'b1;
      bus.from_data  = 32'h44;
      repeat (3) @(negedge clk);
      chk("t3_full_stall", bus.from_ready, 0);
      bus.pkt_ready = 1'b1;
      send(0, 0, 32'h44);
      send(0, 1, 32'h45);
      for (int i = 1; i <= 5; i++) expect_word(32'h40 + i, i == 5);
      idle_cycles(15);
      check_words("t3");
      chk("t3_pkt_count", pkt_count, STATS ? 16'd3 : 16'd0);

      // header mid-payload aborts the first packet
      send(1, 0, 32'h6C30_0000);
      send(0, 0, 32'h51);
      send(0, 0, 32'h52);
      s0 = stalls;
      send(1, 0, 32'h6C20_0000);
      send(0, 0, 32'h61);
      send(0, 1, 32'h62);
      expect_word(32'h61, 0);
      expect_word(32'h62, 1);
      idle_cycles(5);
      chk("t4_proto", n_proto, 1);
      chk("t4_header_held", stalls - s0, 1);
      check_words("t4");
      chk("t4_drop_count", drop_count, STATS ? 16'd2 : 16'd0);
      chk("t4_pkt_count", pkt_count, STATS ? 16'd4 : 16'd0);

      // len 0 stays IDLE; len 9 drops exactly 9 flits
      send(1, 0, 32'h6C00_0000);
      send(1, 0, 32'h6C90_0000);
      for (int i = 0; i < 9; i++) send(0, i == 8, 32'h70 + i);
      send(1, 0, 32'h6C10_0000);
      send(0, 1, 32'h99);
      expect_word(32'h99, 1);
      idle_cycles(5);
      chk("t5_len_errs", n_len, 2);
      chk("t5_proto", n_proto, 1);
      check_words("t5");
      chk("t5_drop_count", drop_count, STATS ? 16'd4 : 16'd0);
      chk("t5_pkt_count", pkt_count, STATS ? 16'd5 : 16'd0);

      // reset mid-payload
      send(1, 0, 32'h6C30_0000);
      send(0, 0, 32'h81);
      send(0, 0, 32'h82);
      rst = 1'b1;
      bus.from_valid = 1'b1;
      bus.from_tail  = 1'b1;
      bus.from_data  = 32'h83;
      @(posedge clk);
      @(negedge clk);
      chk("t6_rst_pkt_valid", bus.pkt_valid, 0);
      chk("t6_rst_from_ready", bus.from_ready, 0);
      chk("t6_rst_counts", {pkt_count, drop_count}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.from_valid = 1'b0;
      bus.from_tail  = 1'b0;
      send(1, 0, 32'h6C30_0000);
      send(0, 0, 32'h91);
      send(0, 0, 32'h92);
      send(0, 1, 32'h93);
      expect_word(32'h91, 0);
      expect_word(32'h92, 0);
      expect_word(32'h93, 1);
      idle_cycles(5);
      check_words("t6");
      chk("t6_proto", n_proto, 1);
      chk("t6_pkt_count", pkt_count, STATS ? 16'd1 : 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/noc_node_receiver.md
Name: noc_node_receiver

Overview:
Local ejection endpoint for one node of the 4x4 mesh NOC. It consumes flits from a router's local "from" port, checks each packet's destination against the node's coordinates, and reassembles payloads into a store-and-forward FIFO. Only complete, well-formed packets are released to the host over a valid/ready interface. It is the receiving counterpart to the node packet injector that drives the router's local "to" port.

Parameters:
DATA_W, 32, flit width in bits. Header field layout below assumes 32.
X_ADDR, 0, this node's column, 0..3.
Y_ADDR, 0, this node's row, 0..3.
FIFO_DEPTH, 8, payload entries in the FIFO. Power of 2, at least 2.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
from_valid  in  1  flit present on the router local output.
from_head  in  1  flit is a header.
from_tail  in  1  flit is the last payload flit.
from_data  in  DATA_W  flit data.
from_ready  out  1  flit accepted on a cycle where from_valid && from_ready.
pkt_valid  out  1  committed payload word available.
pkt_ready  in  1  host accepts the word.
pkt_data  out  DATA_W  payload word.
pkt_src_x  out  2  source column of the packet.
pkt_src_y  out  2  source row of the packet.
pkt_last  out  1  final word of the packet.
err_misroute  out  1  one-cycle pulse: header destination does not match this node.
err_len  out  1  one-cycle pulse: header len is 0 or greater than FIFO_DEPTH.
err_proto  out  1  one-cycle pulse: framing violation.
pkt_count  out  16  packets committed (only with NOC_RX_STATS_EN).
drop_count  out  16  packets dropped or aborted (only with NOC_RX_STATS_EN).

Behaviour:
- Header fields: [31:30] dst_x, [29:28] dst_y, [27:26] src_x, [25:24] src_y, [23:20] len (payload flits, 1..15), [19:0] ignored.
- FSM states: IDLE, PAYLOAD, DROP.
- IDLE, header accepted:
  - len==0 or len>FIFO_DEPTH: pulse err_len, go to DROP with cnt=len. For len==0, stay IDLE instead.
  - Else dst != (X_ADDR,Y_ADDR): pulse err_misroute, go to DROP with cnt=len.
  - Else latch src, set cnt=len, go to PAYLOAD.
- IDLE, non-header flit: consume it, pulse err_proto.
- IDLE, header with from_tail=1: discard it, pulse err_proto, stay IDLE.
- PAYLOAD: each accepted flit is written at the speculative write pointer with {last=(cnt==1), src}, and cnt decrements.
  - from_tail must equal (cnt==1). On mismatch, roll the write pointer back to the commit pointer, pulse err_proto, go to IDLE.
  - On cnt==1 with matching tail, commit pointer = write pointer + 1 at the same edge, go to IDLE.
- PAYLOAD, header arrives: abort. Roll back, pulse err_proto. The header is NOT consumed that cycle (from_ready=0); it is reprocessed from IDLE next cycle.
- DROP: consume cnt flits without writing (from_ready=1), then go to IDLE. A header seen in DROP is handled like a header seen in PAYLOAD.
- from_ready: 0 in rst.
  - 1 in IDLE and DROP, except in the abort case above.
  - In PAYLOAD, 1 iff speculative occupancy (write pointer minus read pointer) < FIFO_DEPTH.
- Host side:
  - pkt_valid = (read pointer != commit pointer), registered FIFO output.
  - Last payload flit accepted at edge N: pkt_valid rises in cycle N+1.
  - Read pointer advances on pkt_valid && pkt_ready.
  - Reads and speculative writes in the same cycle are legal. Full/empty tests use a pointer extra bit for wrap-around.
- A committed packet drains independently of a later aborted packet.
- Reset: synchronous. State IDLE, all pointers 0, cnt 0. All outputs 0, including from_ready. A packet in flight at reset is lost. The host must not hold pkt_ready-dependent state across reset.

Optional Feature:
NOC_RX_STATS_EN:
- Defined: pkt_count increments by 1 on each commit; drop_count increments by 1 on each err_misroute, err_len, or PAYLOAD abort. Both saturate at 0xFFFF and clear on rst.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- X_ADDR=1, Y_ADDR=2. Header 0x6C300000 then payloads 0xA, 0xB, 0xC (tail on 0xC) -> words 0xA, 0xB, 0xC with src (3,0); pkt_last only on 0xC; pkt_valid rises 1 cycle after 0xC is accepted; pkt_count=1.
- Header 0xAC300000 plus 3 payloads -> err_misroute pulses once, nothing on pkt_*, from_ready held 1, drop_count=1.
- pkt_ready=0, FIFO_DEPTH=8, two packets of len 5 -> the first commits; the second stalls with from_ready=0 after 3 flits. Raising pkt_ready drains the first packet, and the second then completes.
- Header len 3 then 2 payloads then a new header -> err_proto, first packet never visible to host; the second packet delivered intact.
- Header len 0 (0x6C000000) -> err_len, state stays IDLE; header len 9 with FIFO_DEPTH 8 -> err_len, 9 flits dropped.
- rst asserted mid-PAYLOAD after 2 of 3 flits -> the next cycle shows pkt_valid=0 and from_ready=0, with counters 0 when NOC_RX_STATS_EN is defined; a following full packet is delivered correctly.
